// File: rtl/sd_cmd_scheduler.sv
// sd_cmd_scheduler
//   Arbitrates between two command sources (req0 = init sequencer, req1 = host
//   path), latches the winner's command and response type, and sequences the
//   send and receive engines through SEND -> RESP_WAIT -> RECV -> DONE.
//   Each transaction ends with a one-cycle done pulse and a status code.
//
// Ports
//   ex_clk, reset           clock, asynchronous active-high reset
//   req0/1, cmd0/1, rtype0/1  requests, {index,argument}, response type
//   sd_finished             send engine finished the command
//   sd_receive_started      receive engine saw a response start bit
//   sd_receive_finished     receive engine finished the response
//   crc_response_err        response CRC error (sampled with receive_finished)
//   gnt0/1, done0/1         grant (through DONE) and completion pulse
//   status                  00 OK, 01 CRC error, 10 timeout (held until next done)
//   send_en, receive_en     engine enables
//   R2_response, R3_response  response format hints for the receive engine
//   send_cmd_content        latched command
//   busy                    high whenever not IDLE
//
// Configuration
//   SD_CMD_RETRY_EN  when defined, a CRC error or timeout re-runs the latched
//                    command once before DONE; status reports the retry result.
//
// All outputs come straight from registers loaded from the next-state decode.

module sd_cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        ex_clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [37:0] cmd0,
  input  logic [37:0] cmd1,
  input  logic [1:0]  rtype0,
  input  logic [1:0]  rtype1,
  input  logic        sd_finished,
  input  logic        sd_receive_started,
  input  logic        sd_receive_finished,
  input  logic        crc_response_err,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [1:0]  status,
  output logic        send_en,
  output logic        receive_en,
  output logic        R2_response,
  output logic        R3_response,
  output logic [37:0] send_cmd_content,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_RESP_WAIT, S_RECV, S_DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic        r_sel, w_sel;      // requester owning the current transaction
  logic        r_last;            // last granted requester (round-robin pointer)
  logic [1:0]  r_rtype;
  logic [15:0] r_cnt, w_cnt;
  logic [1:0]  r_status, w_status;
  logic [37:0] r_cmd;
  logic        w_grant;
  logic        w_fail;
  logic [1:0]  w_fail_code;
  logic        r_gnt0, r_gnt1, r_done0, r_done1;
  logic        r_send_en, r_recv_en, r_r2, r_r3, r_busy;
  logic        w_recv_phase;
`ifdef SD_CMD_RETRY_EN
  logic        r_retried, w_retry_set;
`endif

  always_comb begin
    w_next      = r_state;
    w_sel       = r_sel;
    w_cnt       = r_cnt;
    w_status    = r_status;
    w_grant     = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
`ifdef SD_CMD_RETRY_EN
    w_retry_set = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant = 1'b1;
          // with both pending, the one not served last wins
          w_sel   = (req0 && req1) ? ~r_last : req1;
          w_next  = S_SEND;
        end
      end
      S_SEND: begin
        if (sd_finished) begin
          if (r_rtype == 2'b00) begin
            w_next   = S_DONE;
            w_status = 2'b00;
          end else begin
            w_next = S_RESP_WAIT;
            w_cnt  = '0;
          end
        end
      end
      S_RESP_WAIT: begin
        // a start bit seen on the timeout cycle still counts as a response
        if (sd_receive_started) begin
          w_next = S_RECV;
        end else if (r_cnt == TO_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = 2'b10;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_RECV: begin
        if (sd_receive_finished) begin
          // R3 carries no valid CRC, so its CRC flag is ignored
          if (crc_response_err && (r_rtype != 2'b11)) begin
            w_fail      = 1'b1;
            w_fail_code = 2'b01;
          end else begin
            w_next   = S_DONE;
            w_status = 2'b00;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    if (w_fail) begin
`ifdef SD_CMD_RETRY_EN
      if (!r_retried) begin
        w_next      = S_SEND;
        w_retry_set = 1'b1;
      end else begin
        w_next   = S_DONE;
        w_status = w_fail_code;
      end
`else
      w_next   = S_DONE;
      w_status = w_fail_code;
`endif
    end
  end

  assign w_recv_phase = (w_next == S_RESP_WAIT) || (w_next == S_RECV);

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_rtype   <= 2'b00;
      r_cnt     <= '0;
      r_status  <= 2'b00;
      r_cmd     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_send_en <= 1'b0;
      r_recv_en <= 1'b0;
      r_r2      <= 1'b0;
      r_r3      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_status <= w_status;
      if (w_grant) begin
        r_sel   <= w_sel;
        r_last  <= w_sel;
        r_cmd   <= w_sel ? cmd1 : cmd0;
        r_rtype <= w_sel ? rtype1 : rtype0;
      end
      r_gnt0    <= (w_next != S_IDLE) && !w_sel;
      r_gnt1    <= (w_next != S_IDLE) &&  w_sel;
      r_done0   <= (w_next == S_DONE) && !w_sel;
      r_done1   <= (w_next == S_DONE) &&  w_sel;
      r_send_en <= (w_next == S_SEND);
      r_recv_en <= w_recv_phase;
      r_r2      <= w_recv_phase && (r_rtype == 2'b10);
      r_r3      <= w_recv_phase && (r_rtype == 2'b11);
      r_busy    <= (w_next != S_IDLE);
    end
  end

`ifdef SD_CMD_RETRY_EN
  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset)            r_retried <= 1'b0;
    else if (w_grant)     r_retried <= 1'b0;
    else if (w_retry_set) r_retried <= 1'b1;
  end
`endif

  assign gnt0             = r_gnt0;
  assign gnt1             = r_gnt1;
  assign done0            = r_done0;
  assign done1            = r_done1;
  assign status           = r_status;
  assign send_en          = r_send_en;
  assign receive_en       = r_recv_en;
  assign R2_response      = r_r2;
  assign R3_response      = r_r3;
  assign send_cmd_content = r_cmd;
  assign busy             = r_busy;

endmodule
